// File: rtl/answer_entry.sv
`default_nettype none
// ============================================================================
// Module   : answer_entry
// Purpose  : Player answer capture for the mental-math game. Debounces submit,
//            converts the BCD entry, times the answer, reports a one-shot verdict.
// Revision : 1.0  initial release
// ============================================================================
module answer_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic [6:0] expected,
  input  logic [7:0] switch,
  input  logic       submit,
  output logic       busy,
  output logic       ans_valid,
  output logic       ans_correct,
  output logic       ans_timeout,
  output logic [6:0] ans_value,
  output logic       entry_err,
  output logic [3:0] time_left
);

  localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_cw = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_tx = c_tw + 4;

  localparam logic [c_tw-1:0] c_timer_load = c_tw'(TIMEOUT_CYCLES);
  localparam logic [c_tw-1:0] c_timer_one  = c_tw'(1);
  localparam logic [c_cw-1:0] c_deb_last   = c_cw'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cw-1:0] c_cnt_one    = c_cw'(1);
  localparam logic [c_tx-1:0] c_sat_limit  = c_tx'(15);

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_wait_rel = 2'd1;
  localparam logic [1:0] c_entry    = 2'd2;
  localparam logic [1:0] c_done     = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_deb;
  logic            r_deb_d;
  logic [c_cw-1:0] r_cnt;
  logic            r_sub_edge;

  logic [6:0]      r_expected;
  logic [c_tw-1:0] r_timer;
  logic            r_correct;
  logic            r_timeout;
  logic [6:0]      r_value;
  logic            r_entry_err;

  logic [6:0]      w_tens7;
  logic [6:0]      w_bin;
  logic            w_bcd_ok;
  logic [c_tx-1:0] w_timer_ext;

  logic            w_busy;
  logic            w_ans_valid;
  logic            w_arm_accept;
  logic            w_in_entry;
  logic            w_submit_ok;
  logic            w_submit_bad;
  logic            w_expire;
  logic [3:0]      w_time_left;

  // Switch is held static by the player, so it is decoded directly.
  assign w_tens7     = {3'b000, switch[7:4]};
  assign w_bin       = (w_tens7 << 3) + (w_tens7 << 1) + {3'b000, switch[3:0]};
  assign w_bcd_ok    = (switch[7:4] <= 4'd9) && (switch[3:0] <= 4'd9);
  assign w_timer_ext = {4'b0000, r_timer};

  // Submit conditioning: 2-FF synchronizer, run-length debouncer, rise detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_deb      <= 1'b0;
      r_deb_d    <= 1'b0;
      r_cnt      <= '0;
      r_sub_edge <= 1'b0;
    end else begin
      r_sync1    <= submit;
      r_sync2    <= r_sync1;
      r_deb_d    <= r_deb;
      r_sub_edge <= r_deb & ~r_deb_d;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_deb_last) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:     if (arm) w_next_state = c_wait_rel;
      c_wait_rel: if (!r_deb) w_next_state = c_entry;
      c_entry:    if ((r_sub_edge && w_bcd_ok) || (r_timer == '0)) w_next_state = c_done;
      c_done:     w_next_state = c_idle;
      default:    w_next_state = c_idle;
    endcase
  end

  always_comb begin
    w_busy       = (r_state != c_idle);
    w_ans_valid  = (r_state == c_done);
    w_arm_accept = (r_state == c_idle) && arm;
    w_in_entry   = (r_state == c_entry);
    w_submit_ok  = w_in_entry && r_sub_edge && w_bcd_ok;
    w_submit_bad = w_in_entry && r_sub_edge && !w_bcd_ok;
    // A valid submit in the final timer cycle beats the timeout.
    w_expire     = w_in_entry && (r_timer == '0) && !w_submit_ok;
    w_time_left  = 4'd0;
    if (r_state != c_idle) begin
      w_time_left = (w_timer_ext > c_sat_limit) ? 4'hF : w_timer_ext[3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_expected  <= '0;
      r_timer     <= '0;
      r_correct   <= 1'b0;
      r_timeout   <= 1'b0;
      r_value     <= '0;
      r_entry_err <= 1'b0;
    end else begin
      r_entry_err <= w_submit_bad;
      if (w_arm_accept) begin
        r_expected <= expected;
        r_timer    <= c_timer_load;
        r_correct  <= 1'b0;
        r_timeout  <= 1'b0;
        r_value    <= '0;
      end else if (w_in_entry) begin
        if (r_timer != '0) begin
          r_timer <= r_timer - c_timer_one;
        end
        if (w_submit_ok) begin
          r_value   <= w_bin;
          r_correct <= (w_bin == r_expected);
          r_timeout <= 1'b0;
        end else if (w_expire) begin
          r_value   <= '0;
          r_correct <= 1'b0;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign busy        = w_busy;
  assign ans_valid   = w_ans_valid;
  assign ans_correct = r_correct;
  assign ans_timeout = r_timeout;
  assign ans_value   = r_value;
  assign entry_err   = r_entry_err;
  assign time_left   = w_time_left;

endmodule
`default_nettype wire

// File: tb/tb_answer_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_answer_entry
// Purpose  : Self-checking bench for answer_entry against a cycle-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_answer_entry;

  localparam int D = 4;
  localparam int T = 20;
  localparam int L = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic [6:0] expected;
  logic [7:0] switch;
  logic       submit;
  logic       busy;
  logic       ans_valid;
  logic       ans_correct;
  logic       ans_timeout;
  logic [6:0] ans_value;
  logic       entry_err;
  logic [3:0] time_left;

  int n_cmp = 0;
  int n_bad = 0;

  answer_entry #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .expected   (expected),
    .switch     (switch),
    .submit     (submit),
    .busy       (busy),
    .ans_valid  (ans_valid),
    .ans_correct(ans_correct),
    .ans_timeout(ans_timeout),
    .ans_value  (ans_value),
    .entry_err  (entry_err),
    .time_left  (time_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic [L-1:0] press(input int p, input int h);
    logic [L-1:0] w;
    w = '0;
    for (int k = p; k < p + h; k++) w[k] = 1'b1;
    return w;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // One answer round. wave[e] is the raw submit level driven just after edge e
  // (edge 0 is the edge that accepts arm). The model derives the whole expected
  // timeline from the debounce/timer rules before any stimulus is applied.
  task automatic run_round(input string name, input int exp_v, input logic [7:0] sw_a,
                           input logic [7:0] sw_b, input int sw_chg, input bit pre_held,
                           input logic [L-1:0] wave, input int arm_mid);
    int level, run, ent, vedge, vval, s, b, tens, units, tl;
    bit vcor, vto;
    bit err_at[L+1];
    logic [7:0] sw;

    level = pre_held ? 1 : 0;
    run   = 0;
    ent   = pre_held ? -1 : 1;
    vedge = -1;
    vval  = 0;
    vcor  = 1'b0;
    vto   = 1'b0;
    for (int k = 0; k <= L; k++) err_at[k] = 1'b0;
    for (int k = 0; k < L; k++) begin
      b = wave[k] ? 1 : 0;
      if (b != level) begin
        run++;
        if (run == D) begin
          level = b;
          run   = 0;
          if (level == 0 && ent < 0) ent = k + 4;
          if (level == 1 && vedge < 0) begin
            s = k + 4;
            if (ent >= 0 && s >= ent && s <= ent + T && s + 1 < L) begin
              sw    = (s < sw_chg) ? sw_a : sw_b;
              tens  = int'(sw[7:4]);
              units = int'(sw[3:0]);
              if (tens <= 9 && units <= 9) begin
                vedge = s + 1;
                vval  = tens * 10 + units;
                vcor  = (vval == exp_v);
              end else begin
                err_at[s + 1] = 1'b1;
              end
            end
          end
        end
      end else begin
        run = 0;
      end
    end
    if (vedge < 0 && ent >= 0) begin
      vedge = ent + T + 1;
      vto   = 1'b1;
      vval  = 0;
      vcor  = 1'b0;
    end

    switch   = sw_a;
    expected = 7'(exp_v);
    if (pre_held) begin
      submit = 1'b1;
      repeat (D + 5) tick();
    end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int e = 0; e < L; e++) begin
      chk({name, " busy"}, 32'(busy), 32'(e <= vedge));
      chk({name, " ans_valid"}, 32'(ans_valid), 32'(e == vedge));
      chk({name, " entry_err"}, 32'(entry_err), 32'(err_at[e]));
      if (e != vedge) begin
        if (e > vedge)    tl = 0;
        else if (e < ent) tl = sat15(T);
        else              tl = sat15(T - (e - ent));
        chk({name, " time_left"}, 32'(time_left), 32'(tl));
      end
      if (e == 0) begin
        chk({name, " cleared correct"}, 32'(ans_correct), 32'd0);
        chk({name, " cleared timeout"}, 32'(ans_timeout), 32'd0);
        chk({name, " cleared value"}, 32'(ans_value), 32'd0);
      end
      if (e == vedge || e == L - 1) begin
        chk({name, " ans_correct"}, 32'(ans_correct), 32'(vcor));
        chk({name, " ans_timeout"}, 32'(ans_timeout), 32'(vto));
        chk({name, " ans_value"}, 32'(ans_value), 32'(vval));
      end
      submit = wave[e];
      switch = (e < sw_chg) ? sw_a : sw_b;
      arm    = (e == arm_mid);
      if (e == arm_mid) expected = 7'((exp_v + 1) % 100);
      tick();
    end
    arm    = 1'b0;
    submit = 1'b0;
  endtask

  initial begin
    int ev, p, h;
    logic [7:0] sw;

    rst      = 1'b1;
    arm      = 1'b0;
    expected = '0;
    switch   = '0;
    submit   = 1'b0;
    repeat (2) tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ans_valid", 32'(ans_valid), 32'd0);
    chk("reset ans_correct", 32'(ans_correct), 32'd0);
    chk("reset ans_timeout", 32'(ans_timeout), 32'd0);
    chk("reset ans_value", 32'(ans_value), 32'd0);
    chk("reset entry_err", 32'(entry_err), 32'd0);
    chk("reset time_left", 32'(time_left), 32'd0);
    rst = 1'b0;
    tick();

    run_round("match37", 37, 8'h37, 8'h37, L, 1'b0, press(2, 8), -1);
    run_round("miss36", 37, 8'h36, 8'h36, L, 1'b0, press(2, 8), -1);
    run_round("bounce", 58, 8'h58, 8'h58, L, 1'b0, press(2, 1) | press(4, 2) | press(7, 12), -1);
    run_round("badbcd", 12, 8'h3A, 8'h12, 10, 1'b0, press(1, 6) | press(13, 8), -1);
    run_round("timeout", 44, 8'h44, 8'h44, L, 1'b0, '0, -1);
    run_round("lastcyc", 71, 8'h71, 8'h71, L, 1'b0, press(14, 10), -1);
    run_round("late", 71, 8'h71, 8'h71, L, 1'b0, press(15, 10), -1);
    run_round("held", 45, 8'h45, 8'h45, L, 1'b0, press(0, 5) | press(11, 10), 3);
    run_round("heldarm", 45, 8'h45, 8'h45, L, 1'b1, press(0, 5) | press(11, 10), 3);

    for (int r = 0; r < 6; r++) begin
      ev = int'($urandom_range(0, 99));
      if ($urandom_range(0, 1) == 1) sw = to_bcd(ev);
      else sw = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 7) == 0) sw[3:0] = 4'hB;
      p = int'($urandom_range(1, 16));
      h = int'($urandom_range(D + 1, D + 8));
      run_round("random", ev, sw, sw, L, 1'b0, press(p, h), -1);
    end

    // Reset while in ENTRY with a press in flight.
    expected = 7'd5;
    switch   = 8'h05;
    arm      = 1'b1;
    tick();
    arm      = 1'b0;
    repeat (2) tick();
    submit = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ans_valid", 32'(ans_valid), 32'd0);
    chk("rst ans_correct", 32'(ans_correct), 32'd0);
    chk("rst ans_timeout", 32'(ans_timeout), 32'd0);
    chk("rst ans_value", 32'(ans_value), 32'd0);
    chk("rst entry_err", 32'(entry_err), 32'd0);
    chk("rst time_left", 32'(time_left), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int e = 0; e < 30; e++) begin
      chk("post-rst ans_valid", 32'(ans_valid), 32'd0);
      chk("post-rst busy", 32'(busy), 32'd0);
      if (e == 12) submit = 1'b0;
      tick();
    end

    run_round("after-rst", 9, 8'h09, 8'h09, L, 1'b0, press(3, 7), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
